// File: rtl/ldpc_pkg.sv
// Shared types and size helpers for the streaming LDPC encoder.
package ldpc_pkg;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   // Number of parity bits.
   function automatic int unsigned calc_m(input int unsigned n, input int unsigned k);
      return n - k;
   endfunction

   // Number of input beats per codeword.
   function automatic int unsigned calc_beats(input int unsigned k, input int unsigned p);
      return k / p;
   endfunction

   // Beat counter width, never narrower than one bit.
   function automatic int unsigned calc_cnt_w(input int unsigned k, input int unsigned p);
      int unsigned beats;
      beats = k / p;
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/ldpc_encode_stream_row_accum.sv
// Combinational GF(2) parity increment for one input beat: XOR of the
// generator rows selected by the set info bits of this beat.
module gf2_row_accum
   import ldpc_pkg::*;
#(
   parameter int unsigned K = 3,
   parameter int unsigned M = 3,
   parameter int unsigned P = 1
) (
   input  logic [calc_cnt_w(K, P)-1:0] beat_cnt,
   input  logic [P-1:0]                s_bits,
   input  logic [K*M-1:0]              generator_p,
   output logic [M-1:0]                parity_incr
);

   // Row index of bit p in this beat is beat_cnt*P + p.
   always_comb begin
      parity_incr = '0;
      for (int unsigned p = 0; p < P; p++) begin
         parity_incr = parity_incr ^
            ({M{s_bits[p]}} & generator_p[(32'(beat_cnt) * P + p) * M +: M]);
      end
   end

endmodule

// File: rtl/ldpc_encode_stream.sv
// Multi-cycle systematic linear-block encoder: takes P info bits per beat,
// accumulates parity over GF(2), then holds the full codeword until accepted.
module ldpc_encode_stream
   import ldpc_pkg::*;
#(
   parameter int unsigned N = 6,
   parameter int unsigned K = 3,
   parameter int unsigned P = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic [K*(N-K)-1:0] generator_p,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [P-1:0]     s_bits,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [N-1:0]     m_codeword,
   output logic             busy
);

   localparam int unsigned M     = calc_m(N, K);
   localparam int unsigned BEATS = calc_beats(K, P);
   localparam int unsigned CNT_W = calc_cnt_w(K, P);

   if (K % P != 0) begin : g_bad_p
      $error("ldpc_encode_stream: K must be a multiple of P");
   end
   if (K >= N) begin : g_bad_k
      $error("ldpc_encode_stream: K must be less than N");
   end

   state_t             state, state_next;
   logic [CNT_W-1:0]   beat_cnt;
   logic [M-1:0]       parity, parity_incr, parity_next;
   logic [K-1:0]       info, info_next;
   logic               beat_fire;
   logic               last_beat;

   assign beat_fire = s_valid & s_ready;
   assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
   assign busy      = (state != ST_ACCUM) || (beat_cnt != '0);

   gf2_row_accum #(
      .K (K),
      .M (M),
      .P (P)
   ) u_row_accum (
      .beat_cnt    (beat_cnt),
      .s_bits      (s_bits),
      .generator_p (generator_p),
      .parity_incr (parity_incr)
   );

   // Info/parity values as they would be after taking the current beat.
   always_comb begin
      info_next = info;
      info_next[32'(beat_cnt) * P +: P] = s_bits;
      parity_next = parity ^ parity_incr;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_ACCUM;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and input-ready decode.
   always_comb begin
      state_next = state;
      s_ready    = 1'b0;
      unique case (state)
         ST_ACCUM: begin
            s_ready = i_en;
            if (s_valid && i_en && last_beat) begin
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (m_ready) begin
               state_next = ST_ACCUM;
            end
         end
         default: state_next = ST_ACCUM;
      endcase
   end

   // Beat counter, accumulators and output codeword register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt   <= '0;
         parity     <= '0;
         info       <= '0;
         m_valid    <= 1'b0;
         m_codeword <= '0;
      end else begin
         if (beat_fire) begin
            info   <= info_next;
            parity <= parity_next;
            if (last_beat) begin
               m_codeword <= {parity_next, info_next};
               m_valid    <= 1'b1;
               beat_cnt   <= '0;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
         if ((state == ST_HOLD) && m_ready) begin
            m_valid <= 1'b0;
            parity  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ldpc_encode_stream.sv
// Directed and randomised bench for ldpc_encode_stream with a codeword scoreboard.
module tb_ldpc_encode_stream;

   localparam logic [8:0] G6  = 9'b110_101_011;
   localparam int unsigned NCW = 40;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT A: N=6 K=3 P=1
   logic       a_en, a_sv, a_sr, a_mv, a_mr, a_busy;
   logic [0:0] a_bits;
   logic [5:0] a_cw;
   // DUT B: N=6 K=3 P=3
   logic       b_en, b_sv, b_sr, b_mv, b_mr, b_busy;
   logic [2:0] b_bits;
   logic [5:0] b_cw;
   // DUT C: N=16 K=8 P=2
   logic        c_en, c_sv, c_sr, c_mv, c_mr, c_busy;
   logic [1:0]  c_bits;
   logic [15:0] c_cw;
   logic [63:0] g16;

   logic [5:0]  qa[$];
   logic [5:0]  qb[$];
   logic [15:0] qc[$];

   ldpc_encode_stream #(.N(6), .K(3), .P(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .i_en(a_en), .generator_p(G6),
      .s_valid(a_sv), .s_ready(a_sr), .s_bits(a_bits),
      .m_valid(a_mv), .m_ready(a_mr), .m_codeword(a_cw), .busy(a_busy)
   );

   ldpc_encode_stream #(.N(6), .K(3), .P(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .i_en(b_en), .generator_p(G6),
      .s_valid(b_sv), .s_ready(b_sr), .s_bits(b_bits),
      .m_valid(b_mv), .m_ready(b_mr), .m_codeword(b_cw), .busy(b_busy)
   );

   ldpc_encode_stream #(.N(16), .K(8), .P(2)) dut_c (
      .clk(clk), .rst_n(rst_n), .i_en(c_en), .generator_p(g16),
      .s_valid(c_sv), .s_ready(c_sr), .s_bits(c_bits),
      .m_valid(c_mv), .m_ready(c_mr), .m_codeword(c_cw), .busy(c_busy)
   );

   // Reference: cw[k+i] = XOR_j(info[j] & G[j*m+i]), info bits copied through.
   function automatic logic [15:0] ref_cw(input int unsigned n, input int unsigned k,
                                          input logic [63:0] g, input logic [15:0] info);
      logic [15:0] cw;
      int unsigned m;
      m  = n - k;
      cw = '0;
      for (int unsigned j = 0; j < k; j++) cw[j] = info[j];
      for (int unsigned i = 0; i < m; i++) begin
         logic b;
         b = 1'b0;
         for (int unsigned j = 0; j < k; j++) b = b ^ (info[j] & g[j*m + i]);
         cw[k + i] = b;
      end
      return cw;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic a_send(input logic b);
      int n;
      a_sv = 1'b1;
      a_bits = b;
      #1;
      n = 0;
      while (!a_sr && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("a_send_timeout", 64'd0, 64'd1);
      @(posedge clk);
      @(negedge clk);
      a_sv = 1'b0;
   endtask

   task automatic b_send(input logic [2:0] b);
      int n;
      b_sv = 1'b1;
      b_bits = b;
      #1;
      n = 0;
      while (!b_sr && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("b_send_timeout", 64'd0, 64'd1);
      @(posedge clk);
      @(negedge clk);
      b_sv = 1'b0;
   endtask

   task automatic a_pop_check(input string tag);
      if (qa.size() == 0) check({tag, "_empty"}, 64'd0, 64'd1);
      else check(tag, 64'(a_cw), 64'(qa.pop_front()));
   endtask

   task automatic b_pop_check(input string tag);
      if (qb.size() == 0) check({tag, "_empty"}, 64'd0, 64'd1);
      else check(tag, 64'(b_cw), 64'(qb.pop_front()));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t_first;
      int          sent, got, beat;
      logic [7:0]  cur_info;
      logic        prev_hold;
      logic [15:0] prev_cw;

      rst_n = 1'b0;
      a_en = 1'b1; a_sv = 1'b0; a_bits = '0; a_mr = 1'b0;
      b_en = 1'b1; b_sv = 1'b0; b_bits = '0; b_mr = 1'b0;
      c_en = 1'b1; c_sv = 1'b0; c_bits = '0; c_mr = 1'b0;
      g16 = '0;
      repeat (2) @(negedge clk);
      check("rst_mvalid", 64'(a_mv), 64'd0);
      check("rst_cw", 64'(a_cw), 64'd0);
      check("rst_busy", 64'(a_busy), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // T1: P=1, info 101
      a_mr = 1'b1;
      qa.push_back(6'b101_101);
      a_send(1'b1);
      check("t1_busy_mid", 64'(a_busy), 64'd1);
      a_send(1'b0);
      a_send(1'b1);
      check("t1_mvalid", 64'(a_mv), 64'd1);
      check("t1_sready_hold", 64'(a_sr), 64'd0);
      a_pop_check("t1_cw");
      @(negedge clk);
      check("t1_mvalid_drop", 64'(a_mv), 64'd0);
      check("t1_sready_back", 64'(a_sr), 64'd1);

      // T2: P=3, back-to-back codewords two cycles apart
      b_mr = 1'b1;
      qb.push_back(6'b000_111);
      b_send(3'b111);
      check("t2_mvalid_a", 64'(b_mv), 64'd1);
      t_first = cyc;
      b_pop_check("t2_cw_a");
      qb.push_back(6'b011_001);
      b_send(3'b001);
      check("t2_mvalid_b", 64'(b_mv), 64'd1);
      b_pop_check("t2_cw_b");
      check("t2_spacing", 64'(cyc - t_first), 64'd2);
      @(negedge clk);

      // T3: P=1, back-pressure holds codeword
      a_mr = 1'b0;
      qa.push_back(6'b110_011);
      a_send(1'b1);
      a_send(1'b1);
      a_send(1'b0);
      a_pop_check("t3_cw");
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_mvalid", 64'(a_mv), 64'd1);
         check("t3_hold_cw", 64'(a_cw), 64'h33);
         check("t3_hold_sready", 64'(a_sr), 64'd0);
         @(negedge clk);
      end
      a_mr = 1'b1;
      @(negedge clk);
      check("t3_release_mvalid", 64'(a_mv), 64'd0);
      check("t3_release_sready", 64'(a_sr), 64'd1);

      // T4: i_en low blocks beats while s_valid stays high
      qa.push_back(6'b110_011);
      a_send(1'b1);
      a_en = 1'b0;
      a_sv = 1'b1;
      a_bits = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("t4_sready_blocked", 64'(a_sr), 64'd0);
         check("t4_busy", 64'(a_busy), 64'd1);
      end
      a_en = 1'b1;
      a_send(1'b1);
      a_send(1'b0);
      check("t4_mvalid", 64'(a_mv), 64'd1);
      a_pop_check("t4_cw");
      @(negedge clk);

      // T5: reset mid-codeword discards partial work
      a_send(1'b1);
      a_send(1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_mvalid", 64'(a_mv), 64'd0);
      check("t5_rst_cw", 64'(a_cw), 64'd0);
      check("t5_rst_busy", 64'(a_busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      qa.push_back(6'b110_100);
      a_send(1'b0);
      a_send(1'b0);
      a_send(1'b1);
      check("t5_mvalid", 64'(a_mv), 64'd1);
      a_pop_check("t5_cw");
      @(negedge clk);

      // T6: N=16 K=8 P=2, random G and random backpressure
      g16 = {$urandom, $urandom};
      sent = 0;
      got = 0;
      beat = 0;
      cur_info = 8'($urandom);
      prev_hold = 1'b0;
      prev_cw = '0;
      for (int t = 0; t < 4000 && got < int'(NCW); t++) begin
         @(negedge clk);
         if (prev_hold) begin
            check("t6_hold_valid", 64'(c_mv), 64'd1);
            check("t6_hold_stable", 64'(c_cw), 64'(prev_cw));
         end
         c_mr = ($urandom_range(0, 3) != 0);
         c_sv = (sent < int'(NCW)) && ($urandom_range(0, 3) != 0);
         c_bits = cur_info[2*beat +: 2];
         #1;
         if (c_mv && c_mr) begin
            if (qc.size() == 0) check("t6_unexpected_cw", 64'd0, 64'd1);
            else check("t6_cw", 64'(c_cw), 64'(qc.pop_front()));
            got++;
         end
         prev_hold = c_mv && !c_mr;
         prev_cw = c_cw;
         if (c_sv && c_sr) begin
            if (beat == 3) begin
               qc.push_back(ref_cw(16, 8, g16, {8'b0, cur_info}));
               sent++;
               beat = 0;
               cur_info = 8'($urandom);
            end else begin
               beat++;
            end
         end
      end
      check("t6_count", 64'(got), 64'(NCW));
      check("t6_queue_empty", 64'(qc.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
